// File: rtl/aes_iter_core.sv
`default_nettype none
//==============================================================================
// Module   : aes_iter_core (with helper aes_sbox)
// Brief    : Iterative valid/ready AES encryption core, AES-128 or AES-256,
//            one round per cycle with on-the-fly key expansion.
//            Optional macro AES_ABORT_EN adds an abort input.
// Revision : 1.0 - initial release
//==============================================================================

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry 0 sits in the top byte, so index by the complemented address.
    assign out_byte = c_sbox[{~in_byte, 3'b000} +: 8];
endmodule

module aes_iter_core #(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef AES_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [KEY_LEN-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data
);
    localparam int NR = (KEY_LEN == 256) ? 14 : 10;
    localparam logic [3:0] c_nr = 4'(NR);

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

    state_t       r_fsm, w_fsm_next;
    logic         r_in_ready, w_in_ready_next;
    logic         r_out_valid, w_out_valid_next;
    logic [127:0] r_out_data;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic         w_accept, w_step;
    logic [127:0] w_sr, w_mc, w_rk, w_round_out;
    logic [7:0]   w_sb [16];
    logic [31:0]  w_key_sub, w_key_rot;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Chained word XOR shared by both key schedules; temp feeds word 0.
    function automatic logic [127:0] expand(input logic [127:0] base, input logic [31:0] temp);
        logic [31:0] n0, n1, n2, n3;
        n0 = base[127:96] ^ temp;
        n1 = base[95:64]  ^ n0;
        n2 = base[63:32]  ^ n1;
        n3 = base[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    generate
        for (genvar k = 0; k < 16; k++) begin : g_sbox
            aes_sbox u_sbox (.in_byte(r_state[127-8*k -: 8]), .out_byte(w_sb[k]));
        end
        for (genvar j = 0; j < 4; j++) begin : g_key_sbox
            aes_sbox u_sbox (.in_byte(r_key[31-8*j -: 8]), .out_byte(w_key_sub[31-8*j -: 8]));
        end
    endgenerate

    // SubWord and RotWord commute, so one set of key S-boxes serves both.
    assign w_key_rot = {w_key_sub[23:0], w_key_sub[31:24]};

    always_comb begin
        w_sr = '0;
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = w_sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
    end

    assign w_round_out = ((r_rnd == c_nr) ? w_sr : w_mc) ^ w_rk;

    generate
        if (KEY_LEN == 128) begin : g_ks128
            assign w_rk = expand(r_key, w_key_rot ^ {rcon(r_rnd), 24'h0});
        end else if (KEY_LEN == 256) begin : g_ks256
            logic [127:0] r_prev;
            logic [31:0]  w_temp;
            // Round 1 uses the second key half as-is; expansion starts at round 2.
            assign w_temp = r_rnd[0] ? w_key_sub : (w_key_rot ^ {rcon({1'b0, r_rnd[3:1]}), 24'h0});
            assign w_rk   = (r_rnd == 4'd1) ? r_key : expand(r_prev, w_temp);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev <= '0;
                end else if (w_accept) begin
                    r_prev <= in_key[255:128];
                end else if (w_step && (r_rnd != 4'd1)) begin
                    r_prev <= r_key;
                end
            end
        end else begin : g_bad_key_len
            $error("aes_iter_core: KEY_LEN must be 128 or 256");
            assign w_rk = '0;
        end
    endgenerate

    always_comb begin
        w_fsm_next       = r_fsm;
        w_in_ready_next  = r_in_ready;
        w_out_valid_next = r_out_valid;
        w_accept         = 1'b0;
        w_step           = 1'b0;
        case (r_fsm)
            IDLE: begin
                w_in_ready_next = 1'b1;
                if (in_valid && in_ready) begin
                    w_accept        = 1'b1;
                    w_in_ready_next = 1'b0;
                    w_fsm_next      = ROUND;
                end
            end
            ROUND: begin
                w_step = 1'b1;
                if (r_rnd == c_nr) begin
                    w_out_valid_next = 1'b1;
                    w_fsm_next       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_in_ready_next  = 1'b1;
                    w_fsm_next       = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
`ifdef AES_ABORT_EN
        if (abort && (r_fsm != IDLE)) begin
            w_step           = 1'b0;
            w_out_valid_next = 1'b0;
            w_in_ready_next  = 1'b1;
            w_fsm_next       = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_rnd       <= '0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_in_ready  <= w_in_ready_next;
            r_out_valid <= w_out_valid_next;
            if (w_accept) begin
                r_state <= in_data ^ in_key[KEY_LEN-1 -: 128];
                r_key   <= in_key[127:0];
                r_rnd   <= 4'd1;
            end else if (w_step) begin
                r_state <= w_round_out;
                r_key   <= w_rk;
                r_rnd   <= r_rnd + 4'd1;
                if (r_rnd == c_nr) begin
                    r_out_data <= w_round_out;
                end
            end
        end
    end

`ifdef AES_ABORT_EN
    assign in_ready = r_in_ready & ~abort;
`else
    assign in_ready = r_in_ready;
`endif
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
//==============================================================================
// Module   : tb_aes_iter_core
// Brief    : Scoreboard bench for aes_iter_core, one AES-128 and one AES-256
//            instance driven with FIPS-197 vectors.
// Revision : 1.0 - initial release
//==============================================================================
module tb_aes_iter_core;
    localparam logic [127:0] c_key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_pt1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_ct1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_key2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] c_key3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_ct3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [127:0] in_data_a, in_key_a, out_data_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [127:0] in_data_b, out_data_b;
    logic [255:0] in_key_b;
`ifdef AES_ABORT_EN
    logic         abort_a, abort_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] q_a[$];
    logic [127:0] q_b[$];
    logic [127:0] exp_a, exp_b;

    always #5 clk = ~clk;

    aes_iter_core #(.KEY_LEN(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
        .abort(abort_a),
`endif
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_key(in_key_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a)
    );

    aes_iter_core #(.KEY_LEN(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
        .abort(abort_b),
`endif
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_key(in_key_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read there or at negedge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept_blk(input bit sel, input logic [127:0] d, input logic [255:0] k);
        int t;
        if (!sel) begin
            in_valid_a = 1'b1; in_data_a = d; in_key_a = k[127:0];
        end else begin
            in_valid_b = 1'b1; in_data_b = d; in_key_b = k;
        end
        t = 0;
        while (((sel ? in_ready_b : in_ready_a) !== 1'b1) && (t < 50)) begin
            tick();
            t++;
        end
        if (t >= 50) check("accept_timeout", 128'(t), 128'd0);
        tick();
        if (!sel) in_valid_a = 1'b0; else in_valid_b = 1'b0;
    endtask

    // The accept edge counts as edge 1.
    task automatic wait_out(input bit sel, input int req_lat);
        int cnt;
        cnt = 1;
        while (((sel ? out_valid_b : out_valid_a) !== 1'b1) && (cnt < 60)) begin
            tick();
            cnt++;
        end
        check(sel ? "latency_256" : "latency_128", 128'(cnt), 128'(req_lat));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("mon_a_unexpected_out", 128'd1, 128'd0);
            end else begin
                exp_a = q_a.pop_front();
                check("mon_a_data", out_data_a, exp_a);
            end
        end
        if (rst_n === 1'b1 && out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("mon_b_unexpected_out", 128'd1, 128'd0);
            end else begin
                exp_b = q_b.pop_front();
                check("mon_b_data", out_data_b, exp_b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; in_key_a = '0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; in_key_b = '0; out_ready_b = 1'b0;
`ifdef AES_ABORT_EN
        abort_a = 1'b0; abort_b = 1'b0;
`endif
        repeat (3) tick();
        check("rst_in_ready_a",  128'(in_ready_a),  128'd0);
        check("rst_out_valid_a", 128'(out_valid_a), 128'd0);
        check("rst_out_data_a",  out_data_a,        128'd0);
        check("rst_in_ready_b",  128'(in_ready_b),  128'd0);
        check("rst_out_valid_b", 128'(out_valid_b), 128'd0);
        check("rst_out_data_b",  out_data_b,        128'd0);
        rst_n = 1'b1;
        check("ready_before_edge", 128'(in_ready_a), 128'd0);
        tick();
        check("ready_after_edge_a", 128'(in_ready_a), 128'd1);
        check("ready_after_edge_b", 128'(in_ready_b), 128'd1);

        // FIPS-197 AES-128 vectors with out_ready tied high
        out_ready_a = 1'b1;
        q_a.push_back(c_ct1);
        accept_blk(1'b0, c_pt1, {128'h0, c_key1});
        wait_out(1'b0, 11);
        tick();
        q_a.push_back(c_ct2);
        accept_blk(1'b0, c_pt2, {128'h0, c_key2});
        wait_out(1'b0, 11);
        tick();

        // FIPS-197 AES-256 vector
        out_ready_b = 1'b1;
        q_b.push_back(c_ct3);
        accept_blk(1'b1, c_pt2, c_key3);
        wait_out(1'b1, 15);
        tick();

        // Backpressure: output held while the next block waits on in_valid
        out_ready_a = 1'b0;
        q_a.push_back(c_ct1);
        accept_blk(1'b0, c_pt1, {128'h0, c_key1});
        wait_out(1'b0, 11);
        in_valid_a = 1'b1; in_data_a = c_pt2; in_key_a = c_key2;
        for (int i = 0; i < 20; i++) begin
            check("bp_out_data",  out_data_a,         c_ct1);
            check("bp_out_valid", 128'(out_valid_a),  128'd1);
            check("bp_in_ready",  128'(in_ready_a),   128'd0);
            tick();
        end
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        check("bp_ready_after_retire", 128'(in_ready_a), 128'd1);
        q_a.push_back(c_ct2);
        accept_blk(1'b0, c_pt2, {128'h0, c_key2});
        out_ready_a = 1'b1;
        wait_out(1'b0, 11);
        tick();

        // Reset at rnd=5: block discarded, no expectation queued for it
        accept_blk(1'b0, c_pt2, {128'h0, c_key2});
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid_a), 128'd0);
        check("midrst_in_ready",  128'(in_ready_a),  128'd0);
        check("midrst_out_data",  out_data_a,        128'd0);
        tick();
        rst_n = 1'b1;
        check("midrst_ready_before_edge", 128'(in_ready_a), 128'd0);
        tick();
        check("midrst_ready_after_edge", 128'(in_ready_a), 128'd1);
        q_a.push_back(c_ct1);
        accept_blk(1'b0, c_pt1, {128'h0, c_key1});
        wait_out(1'b0, 11);
        tick();

`ifdef AES_ABORT_EN
        // Abort at rnd=3, then abort beating in_valid in IDLE
        accept_blk(1'b0, c_pt2, {128'h0, c_key2});
        repeat (2) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("abort_no_out_valid", 128'(out_valid_a), 128'd0);
            tick();
        end
        check("abort_back_idle", 128'(in_ready_a), 128'd1);
        abort_a = 1'b1; in_valid_a = 1'b1;
        check("abort_masks_ready", 128'(in_ready_a), 128'd0);
        tick();
        abort_a = 1'b0; in_valid_a = 1'b0;
        check("abort_blocked_accept", 128'(in_ready_a), 128'd1);
        q_a.push_back(c_ct1);
        accept_blk(1'b0, c_pt1, {128'h0, c_key1});
        wait_out(1'b0, 11);
        tick();
`endif

        repeat (3) tick();
        check("queue_a_drained", 128'(q_a.size()), 128'd0);
        check("queue_b_drained", 128'(q_b.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
